// File: rtl/keypad_col_scanner.sv
// rtl/keypad_col_scanner.sv - 4x4 keypad row scanner with debounced single-key capture
module keypad_col_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 1000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       row_idx;
    logic [3:0]       col_meta;
    logic [3:0]       col_s;
    logic [3:0]       ref_pat;
    logic [1:0]       col_idx;
    logic             col_ok;

    // Exactly one low column is a usable key; anything else is idle or ghosted.
    always_comb begin
        col_idx = 2'd0;
        col_ok  = 1'b1;
        case (col_s)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_meta  <= 4'b1111;
            col_s     <= 4'b1111;
            state     <= SCAN;
            cnt       <= '0;
            row_idx   <= 2'd0;
            row_out   <= 4'b1110;
            ref_pat   <= 4'b1111;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            col_meta  <= col_in;
            col_s     <= col_meta;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (col_ok) begin
                            state   <= DEBOUNCE;
                            ref_pat <= col_s;
                        end else begin
                            row_out <= {row_out[2:0], row_out[3]};
                            row_idx <= row_idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    // Any deviation abandons the candidate but keeps the current row.
                    if (col_s != ref_pat) begin
                        cnt   <= '0;
                        state <= SCAN;
                    end else if (cnt == DEB_LAST) begin
                        cnt       <= '0;
                        state     <= PRESSED;
                        key_code  <= {row_idx, col_idx};
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (col_s != 4'b1111) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        cnt      <= '0;
                        key_held <= 1'b0;
                        state    <= SCAN;
                        row_out  <= {row_out[2:0], row_out[3]};
                        row_idx  <= row_idx + 2'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= SCAN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_col_scanner.sv
// tb/tb_keypad_col_scanner.sv - directed self-checking bench for keypad_col_scanner
module tb_keypad_col_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    int          row_changes = 0;
    logic [3:0]  prev_row = 4'b1110;
    logic        mon_en = 1'b0;

    keypad_col_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_CNT(8),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .col_in(col_in),
        .row_out(row_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Key matrix: pressed[r*4+c] pulls column c low while row r is driven low.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) pulses++;
        if (row_out !== prev_row) row_changes++;
        prev_row = row_out;
        if (mon_en) check("row_one_cold", $countones(~row_out), 1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!key_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, key_valid, 1);
    endtask

    task automatic wait_release(input string tag, input int budget);
        int n = 0;
        while (key_held && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, key_held, 0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        int rc0;
        pressed = 16'h0;
        rst_n   = 1'b0;
        cycles(3);
        check("rst_row", row_out, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Idle scan: one row step every SCAN_DIV cycles.
        cycles(4); check("idle_row1", row_out, 4'b1101);
        cycles(4); check("idle_row2", row_out, 4'b1011);
        cycles(4); check("idle_row3", row_out, 4'b0111);
        cycles(4); check("idle_wrap", row_out, 4'b1110);
        check("idle_pulses", pulses, 0);
        check("idle_held", key_held, 0);

        // Clean press row2/col1.
        p0 = pulses;
        pressed[2*4+1] = 1'b1;
        wait_valid("clean_strobe", 100);
        check("clean_code", key_code, 4'b1001);
        check("clean_held", key_held, 1);
        check("clean_row_frozen", row_out, 4'b1011);
        cycles(40);
        check("clean_single_pulse", pulses - p0, 1);
        check("clean_row_still", row_out, 4'b1011);
        pressed = 16'h0;
        cycles(9);
        check("clean_held_before", key_held, 1);
        cycles(1);
        check("clean_held_after", key_held, 0);
        check("clean_next_row", row_out, 4'b0111);
        check("clean_code_kept", key_code, 4'b1001);

        // Bounce on row0/col0, then settle.
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            pressed[0] = (i % 2 == 0);
            cycles(3);
        end
        check("bounce_no_strobe", pulses - p0, 0);
        pressed[0] = 1'b1;
        wait_valid("bounce_strobe", 100);
        check("bounce_code", key_code, 4'h0);
        check("bounce_row", row_out, 4'b1110);
        cycles(2);
        check("bounce_single_pulse", pulses - p0, 1);
        pressed = 16'h0;
        wait_release("bounce_release", 40);

        // Two columns low on row1: never accepted, scan keeps moving.
        p0 = pulses;
        pressed[1*4+0] = 1'b1;
        pressed[1*4+1] = 1'b1;
        rc0 = row_changes;
        cycles(40);
        check("multi_no_strobe", pulses - p0, 0);
        check("multi_rotations", row_changes - rc0, 10);
        check("multi_held", key_held, 0);
        pressed = 16'h0;

        // Held key plus a second key on the same row.
        p0 = pulses;
        pressed[3*4+3] = 1'b1;
        wait_valid("held_strobe", 100);
        check("held_code", key_code, 4'hF);
        pressed[3*4+0] = 1'b1;
        cycles(30);
        check("held_no_second", pulses - p0, 1);
        check("held_still", key_held, 1);
        check("held_row", row_out, 4'b0111);
        pressed = 16'h0;
        cycles(9);
        check("held_before_release", key_held, 1);
        cycles(1);
        check("held_released", key_held, 0);
        check("held_wrap_row", row_out, 4'b1110);

        // Exact acceptance latency from reset with row0/col2 held.
        pressed = 16'h0;
        pressed[2] = 1'b1;
        mon_en = 1'b0;
        do_reset();
        mon_en = 1'b1;
        cycles(11);
        check("lat_valid_early", key_valid, 0);
        check("lat_held_early", key_held, 0);
        cycles(1);
        check("lat_valid", key_valid, 1);
        check("lat_code", key_code, 4'b0010);
        cycles(1);
        check("lat_valid_drop", key_valid, 0);
        check("lat_held", key_held, 1);

        // Reset at debounce count 5.
        mon_en = 1'b0;
        do_reset();
        mon_en = 1'b1;
        p0 = pulses;
        cycles(9);
        rst_n = 1'b0;
        cycles(1);
        check("mid_rst_row", row_out, 4'b1110);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_code", key_code, 4'h0);
        rst_n   = 1'b1;
        pressed = 16'h0;
        cycles(20);
        check("mid_rst_no_strobe", pulses - p0, 0);
        check("mid_rst_held_after", key_held, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
